// File: rtl/mlp_pkg.sv
// Shared types and widths for the MLP layer datapath blocks.
package mlp_pkg;

  localparam int BIAS_W = 16;
  localparam int ADDR_W = 8;

  typedef logic signed [15:0] fixp16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bias_seq_state_t;

endpackage

// File: rtl/sat_add.sv
// Signed add of a wide operand and a narrow operand, saturated to the narrow width.
module sat_add #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  a,
  input  logic [OUT_W-1:0] b,
  output logic [OUT_W-1:0] y
);

  logic [IN_W:0] sum;
  logic          ovf;

  always_comb begin
    sum = {a[IN_W-1], a} + {{(IN_W+1-OUT_W){b[OUT_W-1]}}, b};
    // In range only when every bit above the output sign bit copies it.
    ovf = (sum[IN_W:OUT_W-1] != {(IN_W-OUT_W+2){1'b0}}) &&
          (sum[IN_W:OUT_W-1] != {(IN_W-OUT_W+2){1'b1}});
    if (!ovf)
      y = sum[OUT_W-1:0];
    else if (sum[IN_W])
      y = {1'b1, {(OUT_W-1){1'b0}}};
    else
      y = {1'b0, {(OUT_W-1){1'b1}}};
  end

endmodule

// File: rtl/bias_add_sequencer.sv
// Adds the per-neuron bias to each accumulated sum of a layer and forwards it saturated.
//   state | meaning
//   IDLE  | not armed, no input accepted
//   RUN   | accepting sums, idx walks the bias file
//   DRAIN | last sum taken, waiting for its output handshake
module bias_add_sequencer
  import mlp_pkg::*;
#(
  parameter int NUM_NEURONS = 15,
  parameter int ACC_W       = 24,
  parameter int OUT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACC_W-1:0]  in_data,
  output logic [ADDR_W-1:0] bias_addr,
  input  logic [BIAS_W-1:0] bias_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              layer_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  bias_seq_state_t   state, state_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic              out_valid_n;
  logic [OUT_W-1:0]  out_data_n;
  logic [ADDR_W-1:0] out_idx_n;
  logic [OUT_W-1:0]  sat_sum;
  logic              accept;

  sat_add #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat_add (
    .a (in_data),
    .b (bias_data),
    .y (sat_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_idx   <= out_idx_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    out_valid_n = out_valid && !out_ready;
    out_data_n  = out_data;
    out_idx_n   = out_idx;
    in_ready    = 1'b0;
    layer_done  = 1'b0;
    accept      = 1'b0;
    bias_addr   = idx;
    busy        = (state != IDLE);

    if (start) begin
      // A new start aborts whatever layer is in flight, including a pending output.
      state_n     = RUN;
      idx_n       = '0;
      out_valid_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        RUN: begin
          in_ready = !out_valid || out_ready;
          accept   = in_valid && in_ready;
          if (accept) begin
            out_valid_n = 1'b1;
            out_data_n  = sat_sum;
            out_idx_n   = idx;
            if (idx == LAST_IDX) state_n = DRAIN;
            else                 idx_n   = idx + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            layer_done = 1'b1;
            state_n    = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_add_sequencer.sv
// Directed bench for bias_add_sequencer with a transaction-level reference model.
module tb_bias_add_sequencer;
  localparam int N = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_ready, out_valid, layer_done, busy;
  logic [7:0]  bias_addr, out_idx;
  logic [15:0] bias_data, out_data;

  logic        start1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic        in_ready1, out_valid1, layer_done1, busy1;
  logic [7:0]  bias_addr1, out_idx1;
  logic [15:0] bias_data1, out_data1;

  logic [15:0] bias_mem [256];
  assign bias_data  = bias_mem[bias_addr];
  assign bias_data1 = bias_mem[bias_addr1];

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  bias_add_sequencer #(.NUM_NEURONS(N), .ACC_W(24), .OUT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bias_addr(bias_addr), .bias_data(bias_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .layer_done(layer_done),
    .busy(busy));

  bias_add_sequencer #(.NUM_NEURONS(1), .ACC_W(24), .OUT_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .bias_addr(bias_addr1), .bias_data(bias_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .out_idx(out_idx1), .layer_done(layer_done1),
    .busy(busy1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input longint s);
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  // Reference model: layer armed/draining flags, next neuron, one pending output.
  bit          m_busy, m_draining, m_pv;
  int          m_n;
  logic [15:0] m_pd;
  int          m_pi;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_draining <= 0; m_pv <= 0; m_n <= 0; m_pd <= '0; m_pi <= 0;
    end else if (start) begin
      m_busy <= 1; m_draining <= 0; m_pv <= 0; m_n <= 0;
    end else if (m_busy) begin
      automatic bit fire = m_pv && out_ready;
      automatic bit take = !m_draining && in_valid && (!m_pv || out_ready);
      automatic longint a = $signed(in_data);
      automatic longint b = $signed(bias_mem[m_n]);
      if (fire) m_pv <= 0;
      if (m_draining && fire) begin
        m_busy <= 0; m_draining <= 0;
      end
      if (take) begin
        m_pv <= 1;
        m_pd <= sat16(a + b);
        m_pi <= m_n;
        if (m_n == N - 1) m_draining <= 1;
        else              m_n <= m_n + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("in_ready", in_ready, m_busy && !m_draining && !start && (!m_pv || out_ready));
      chk("out_valid", out_valid, m_pv);
      chk("busy", busy, m_busy);
      chk("bias_addr", bias_addr, m_n);
      chk("layer_done", layer_done, m_draining && m_pv && out_ready && !start);
      if (m_pv) begin
        chk("out_data", out_data, m_pd);
        chk("out_idx", out_idx, m_pi);
      end
    end
  end

  logic [23:0] log_q[$];
  int ld_cnt = 0;
  int ld_idx = -1;
  always @(negedge clk) begin
    if (out_valid && out_ready) log_q.push_back({out_idx, out_data});
    if (layer_done) begin
      ld_cnt++;
      ld_idx = out_idx;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int k;
    bit acc;
    int ld_before;
    for (int i = 0; i < 256; i++) bias_mem[i] = 16'(i * 16);

    #2 reset = 1'b1;
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bias_addr", bias_addr, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    check_en = 1'b1;

    // in_valid while idle is ignored
    in_valid = 1'b1; in_data = 24'd5; out_ready = 1'b1;
    cyc(); cyc();
    in_valid = 1'b0;

    // 1: full layer, biases n*16, in_data 100
    log_q.delete();
    pulse_start();
    in_valid = 1'b1; in_data = 24'd100;
    repeat (N) cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("t1_count", log_q.size(), 15);
    for (int i = 0; i < log_q.size() && i < 15; i++) begin
      chk("t1_idx", log_q[i][23:16], i);
      chk("t1_data", log_q[i][15:0], 100 + 16 * i);
    end
    chk("t1_ld_cnt", ld_cnt, 1);
    chk("t1_ld_idx", ld_idx, 14);
    chk("t1_busy_after", busy, 0);

    // 2: saturation
    bias_mem[0] = 16'h0100; bias_mem[1] = 16'h8000; bias_mem[2] = 16'hFFFB;
    log_q.delete();
    pulse_start();
    in_valid = 1'b1;
    in_data = 24'h7FFF00; cyc();
    in_data = 24'h800000; cyc();
    in_data = 24'hFFFFF6; cyc();
    in_valid = 1'b0;
    repeat (2) cyc();
    chk("t2_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t2_pos_sat", log_q[0][15:0], 16'h7FFF);
      chk("t2_neg_sat", log_q[1][15:0], 16'h8000);
      chk("t2_no_sat", log_q[2][15:0], 16'hFFF1);
    end
    for (int i = 0; i < 3; i++) bias_mem[i] = 16'(i * 16);

    // 3: downstream stall for 5 cycles mid-stream
    log_q.delete();
    pulse_start();
    k = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c < 8);
      in_valid  = (k < 15);
      in_data   = 24'(1000 + 3 * k);
      @(negedge clk);
      acc = in_valid && in_ready;
      cyc();
      if (acc) k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("t3_accepted", k, 15);
    chk("t3_count", log_q.size(), 15);
    for (int i = 0; i < log_q.size() && i < 15; i++) begin
      chk("t3_idx", log_q[i][23:16], i);
      chk("t3_data", log_q[i][15:0], 1000 + 19 * i);
    end

    // 4: abort at idx 7 with an output pending
    ld_before = ld_cnt;
    pulse_start();
    in_valid = 1'b1; in_data = 24'd7;
    repeat (7) cyc();
    chk("t4_idx7", bias_addr, 7);
    chk("t4_pending", out_valid, 1);
    start = 1'b1;
    @(negedge clk);
    chk("t4_start_wins", in_ready, 0);
    cyc();
    start = 1'b0; in_valid = 1'b0;
    chk("t4_dropped", out_valid, 0);
    chk("t4_addr0", bias_addr, 0);
    chk("t4_no_done", ld_cnt, ld_before);
    log_q.delete();
    in_valid = 1'b1;
    repeat (N) cyc();
    in_valid = 1'b0;
    repeat (2) cyc();
    chk("t4_first_idx", log_q.size() > 0 ? log_q[0][23:16] : 8'hFF, 0);
    chk("t4_first_data", log_q.size() > 0 ? log_q[0][15:0] : 16'hFFFF, 7);
    chk("t4_done_once", ld_cnt, ld_before + 1);

    // 5: asynchronous reset mid-layer
    pulse_start();
    in_valid = 1'b1; in_data = 24'd1;
    repeat (5) cyc();
    #2 reset = 1'b1;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_out_idx", out_idx, 0);
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 0);
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    chk("t5_idle_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // 6: single-neuron layer
    bias_mem[0] = 16'h0010;
    in_data = 24'd50;
    start1 = 1'b1; cyc(); start1 = 1'b0;
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", in_ready1, 1);
    cyc();
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", out_valid1, 1);
    chk("t6_out_data", out_data1, 16'h0042);
    chk("t6_out_idx", out_idx1, 0);
    chk("t6_drain_in_ready", in_ready1, 0);
    chk("t6_busy", busy1, 1);
    chk("t6_no_done_yet", layer_done1, 0);
    cyc();
    out_ready1 = 1'b1;
    @(negedge clk);
    chk("t6_done", layer_done1, 1);
    cyc();
    in_valid1 = 1'b1;
    @(negedge clk);
    chk("t6_idle_valid", out_valid1, 0);
    chk("t6_idle_busy", busy1, 0);
    chk("t6_idle_in_ready", in_ready1, 0);
    cyc();
    in_valid1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
